alu_barrel16: RTL and testbench



---
 rtl/alu_barrel16_pkg.sv | 19 +
 rtl/barrel_shifter16.sv | 55 +++++
 rtl/alu_barrel16.sv | 106 ++++++++++
 tb/tb_alu_barrel16.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_barrel16_pkg.sv
// rtl/alu_barrel16_pkg.sv - opcode encoding and default widths for alu_barrel16
// Contents: op_t opcode enum, DEFAULT_WIDTH / DEFAULT_SHW datapath defaults
package alu_barrel16_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SHW   = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SLL = 3'd4,
        OP_SRL = 3'd5,
        OP_ROL = 3'd6,
        OP_ROR = 3'd7
    } op_t;

endpackage

// File: rtl/barrel_shifter16.sv
// rtl/barrel_shifter16.sv - combinational logarithmic shifter/rotator built on one right-rotate core
// Ports:
//   data      in  WIDTH  value to shift or rotate
//   amount    in  SHW    shift/rotate distance 0..WIDTH-1
//   dir       in  1      1 = left, 0 = right
//   rotate    in  1      1 = rotate (no fill), 0 = logical shift with zero fill
//   result    out WIDTH  shifted/rotated value
//   shift_out out 1      last bit shifted out (0 for rotates or amount 0)
module barrel_shifter16
    import alu_barrel16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = DEFAULT_SHW
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   amount,
    input  logic             dir,
    input  logic             rotate,
    output logic [WIDTH-1:0] result,
    output logic             shift_out
);

    // A left rotate by n equals a right rotate by (WIDTH - n) mod WIDTH,
    // so a single right-rotate cascade serves every variant.
    logic [SHW-1:0]   rot_amt;
    logic [WIDTH-1:0] stage [SHW+1];
    logic [WIDTH-1:0] rotated;
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] fill_mask;

    assign rot_amt  = dir ? (~amount + SHW'(1)) : amount;
    assign stage[0] = data;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int S = 1 << k;
        assign stage[k+1] = rot_amt[k] ? {stage[k][S-1:0], stage[k][WIDTH-1:S]} : stage[k];
    end

    assign rotated = stage[SHW];

    // Logical shifts keep only the bits that did not wrap around.
    assign ones      = '1;
    assign fill_mask = dir ? (ones << amount) : (ones >> amount);
    assign result    = rotate ? rotated : (rotated & fill_mask);

    // The last bit shifted out is the first one that wrapped: it lands in
    // bit 0 for a left shift and in the MSB for a right shift.
    always_comb begin
        shift_out = 1'b0;
        if (!rotate && (amount != '0)) begin
            shift_out = dir ? rotated[0] : rotated[WIDTH-1];
        end
    end

endmodule

// File: rtl/alu_barrel16.sv
// rtl/alu_barrel16.sv - registered 16-bit ALU with integrated barrel shifter
// Ports:
//   clk       in  1      rising-edge clock
//   rst_n     in  1      asynchronous active-low reset
//   en        in  1      operation valid; result registers load only when set
//   select    in  3      opcode (op_t)
//   shift_mag in  SHW    shift/rotate amount for opcodes 4-7
//   i0        in  WIDTH  operand A / value to shift
//   i1        in  WIDTH  operand B (ops 0-3 only)
//   o         out WIDTH  registered result
//   cout      out 1      registered carry / borrow / shift-out flag
//   zero      out 1      registered flag, set when o is zero
//   o_valid   out 1      registered copy of en
module alu_barrel16
    import alu_barrel16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = DEFAULT_SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       select,
    input  logic [SHW-1:0]   shift_mag,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] o,
    output logic             cout,
    output logic             zero,
    output logic             o_valid
);

    op_t              op;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic             sh_dir;
    logic             sh_rotate;
    logic [WIDTH-1:0] sh_result;
    logic             sh_out;
    logic [WIDTH-1:0] next_o;
    logic             next_cout;

    assign op = op_t'(select);

    // Extra MSB captures carry for add and borrow (i1 > i0) for subtract.
    assign add_full = {1'b0, i0} + {1'b0, i1};
    assign sub_full = {1'b0, i0} - {1'b0, i1};

    assign sh_dir    = (op == OP_SLL) || (op == OP_ROL);
    assign sh_rotate = (op == OP_ROL) || (op == OP_ROR);

    barrel_shifter16 #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .data      (i0),
        .amount    (shift_mag),
        .dir       (sh_dir),
        .rotate    (sh_rotate),
        .result    (sh_result),
        .shift_out (sh_out)
    );

    always_comb begin
        next_o    = '0;
        next_cout = 1'b0;
        case (op)
            OP_ADD: begin
                next_o    = add_full[WIDTH-1:0];
                next_cout = add_full[WIDTH];
            end
            OP_SUB: begin
                next_o    = sub_full[WIDTH-1:0];
                next_cout = sub_full[WIDTH];
            end
            OP_AND: next_o = i0 & i1;
            OP_OR:  next_o = i0 | i1;
            OP_SLL, OP_SRL: begin
                next_o    = sh_result;
                next_cout = sh_out;
            end
            OP_ROL, OP_ROR: next_o = sh_result;
            default: begin
                next_o    = '0;
                next_cout = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o       <= '0;
            cout    <= 1'b0;
            zero    <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= en;
            if (en) begin
                o    <= next_o;
                cout <= next_cout;
                zero <= (next_o == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_barrel16.sv
// tb/tb_alu_barrel16.sv - directed self-checking bench for alu_barrel16
module tb_alu_barrel16;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [2:0]  select;
    logic [3:0]  shift_mag;
    logic [15:0] i0;
    logic [15:0] i1;
    logic [15:0] o;
    logic        cout;
    logic        zero;
    logic        o_valid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  mag;
        logic [15:0] eo;
        logic        ec;
        logic        ez;
    } vec_t;

    alu_barrel16 #(.WIDTH(16), .SHW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .select    (select),
        .shift_mag (shift_mag),
        .i0        (i0),
        .i1        (i1),
        .o         (o),
        .cout      (cout),
        .zero      (zero),
        .o_valid   (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation at the falling edge, let the rising edge capture it,
    // and return 1 time unit after that edge so outputs are stable.
    task automatic drive(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] m);
        @(negedge clk);
        en        = 1'b1;
        select    = s;
        i0        = a;
        i1        = b;
        shift_mag = m;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string name, input vec_t v[]);
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i].sel, v[i].a, v[i].b, v[i].mag);
            checks++;
            if ({o, cout, zero, o_valid} !== {v[i].eo, v[i].ec, v[i].ez, 1'b1}) begin
                errors++;
                $display("FAIL %s[%0d] op=%0d a=%h b=%h mag=%0d: got o=%h cout=%b zero=%b valid=%b, want o=%h cout=%b zero=%b valid=1",
                         name, i, v[i].sel, v[i].a, v[i].b, v[i].mag, o, cout, zero, o_valid,
                         v[i].eo, v[i].ec, v[i].ez);
            end
        end
    endtask

    task automatic test_reset();
        en = 1'b0; select = 3'd0; i0 = '0; i1 = '0; shift_mag = '0;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({o, cout, zero, o_valid} !== 19'd0) begin
            errors++;
            $display("FAIL reset_initial: got o=%h cout=%b zero=%b valid=%b, want all 0", o, cout, zero, o_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'd0, 16'd7, 16'hFFFF, 4'd0);
        checks++;
        if ({o, cout, o_valid} !== {16'd6, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset_add: got o=%0d cout=%b valid=%b, want o=6 cout=1 valid=1", o, cout, o_valid);
        end
        // Assert reset between clock edges while en stays high.
        @(negedge clk);
        select = 3'd0; i0 = 16'd100; i1 = 16'd1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o, cout, zero, o_valid} !== 19'd0) begin
            errors++;
            $display("FAIL reset_midstream: got o=%h cout=%b zero=%b valid=%b, want all 0", o, cout, zero, o_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({o, o_valid} !== 17'd0) begin
            errors++;
            $display("FAIL reset_held_edge: got o=%h valid=%b, want o=0 valid=0", o, o_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'd0, 16'd64, 16'd320, 4'd0);
        checks++;
        if ({o, cout, zero, o_valid} !== {16'd384, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_release_add: got o=%0d cout=%b zero=%b valid=%b, want o=384 cout=0 zero=0 valid=1",
                     o, cout, zero, o_valid);
        end
    endtask

    task automatic test_arith();
        vec_t v[] = '{
            '{3'd1, 16'd80,    16'd50, 4'd0, 16'd30,    1'b0, 1'b0},
            '{3'd1, 16'd50,    16'd80, 4'd0, 16'd65506, 1'b1, 1'b0},
            '{3'd0, 16'hFFFF,  16'd1,  4'd0, 16'd0,     1'b1, 1'b1},
            '{3'd1, 16'd1234,  16'd1234, 4'd9, 16'd0,   1'b0, 1'b1}
        };
        run_table("arith", v);
    endtask

    task automatic test_logic();
        vec_t v[] = '{
            '{3'd2, 16'd50,  16'd4,    4'd0, 16'd0,    1'b0, 1'b1},
            '{3'd3, 16'd500, 16'd1000, 4'd0, 16'd1020, 1'b0, 1'b0},
            '{3'd2, 16'hF0F0, 16'hFF00, 4'd3, 16'hF000, 1'b0, 1'b0}
        };
        run_table("logic", v);
    endtask

    task automatic test_shift();
        vec_t v[] = '{
            '{3'd4, 16'd16,    16'hAAAA, 4'd9,  16'd8192,  1'b0, 1'b0},
            '{3'd4, 16'd16,    16'd0,    4'd2,  16'd64,    1'b0, 1'b0},
            '{3'd5, 16'd16,    16'd0,    4'd4,  16'd1,     1'b0, 1'b0},
            '{3'd5, 16'h0003,  16'd0,    4'd1,  16'd1,     1'b1, 1'b0},
            '{3'd4, 16'h8000,  16'd0,    4'd1,  16'd0,     1'b1, 1'b1},
            '{3'd5, 16'hFFFF,  16'd0,    4'd15, 16'd1,     1'b1, 1'b0},
            '{3'd4, 16'h0003,  16'd0,    4'd15, 16'h8000,  1'b1, 1'b0},
            '{3'd4, 16'hBEEF,  16'd0,    4'd0,  16'hBEEF,  1'b0, 1'b0},
            '{3'd5, 16'h8001,  16'd0,    4'd0,  16'h8001,  1'b0, 1'b0}
        };
        run_table("shift", v);
    endtask

    task automatic test_rotate();
        vec_t v[] = '{
            '{3'd6, 16'd500,   16'd0, 4'd10, 16'hD007, 1'b0, 1'b0},
            '{3'd7, 16'd10,    16'd0, 4'd4,  16'hA000, 1'b0, 1'b0},
            '{3'd6, 16'h1234,  16'd0, 4'd0,  16'h1234, 1'b0, 1'b0},
            '{3'd7, 16'hBEEF,  16'd0, 4'd0,  16'hBEEF, 1'b0, 1'b0},
            '{3'd7, 16'h0001,  16'd0, 4'd15, 16'h0002, 1'b0, 1'b0},
            '{3'd6, 16'h8001,  16'd0, 4'd15, 16'hC000, 1'b0, 1'b0}
        };
        run_table("rotate", v);
    endtask

    task automatic test_back_to_back();
        vec_t v[] = '{
            '{3'd0, 16'd1,     16'd2,     4'd0, 16'h0003, 1'b0, 1'b0},
            '{3'd1, 16'd10,    16'd3,     4'd0, 16'h0007, 1'b0, 1'b0},
            '{3'd2, 16'hF0F0,  16'hFF00,  4'd0, 16'hF000, 1'b0, 1'b0},
            '{3'd3, 16'h0F00,  16'h00F0,  4'd0, 16'h0FF0, 1'b0, 1'b0},
            '{3'd4, 16'h0001,  16'd0,     4'd4, 16'h0010, 1'b0, 1'b0},
            '{3'd5, 16'h0100,  16'd0,     4'd4, 16'h0010, 1'b0, 1'b0},
            '{3'd6, 16'h8001,  16'd0,     4'd1, 16'h0003, 1'b0, 1'b0},
            '{3'd7, 16'h8001,  16'd0,     4'd1, 16'hC000, 1'b0, 1'b0}
        };
        // drive() consumes exactly one rising edge per call, so these land on consecutive cycles.
        run_table("b2b", v);
        @(negedge clk);
        en = 1'b0; select = 3'd0; i0 = 16'd0; i1 = 16'd0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({o, cout, zero, o_valid} !== {16'hC000, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL hold[%0d]: got o=%h cout=%b zero=%b valid=%b, want o=c000 cout=0 zero=0 valid=0",
                         c, o, cout, zero, o_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_rotate();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
